uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
- Receive sequencer for the UART RX path. Synchronises the serial line, finds the start bit, and times mid-bit sampling from a baud counter of CLOCK_BAUD_RATIO clocks per bit.
- Assembles BIT_WIDTH data bits, LSB first, and checks the stop bit.
- Hands each good byte to the consumer through a one-entry valid/ready holding register.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- CLOCK_BAUD_RATIO, 400: clk cycles per bit. Must be ≥ 4. HALF = CLOCK_BAUD_RATIO/2, truncated.
- BIT_WIDTH, 8: data bits per frame, from 1 to 16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rx  in  1  serial line. Asynchronous to clk; idles high.
- ready  in  1  consumer accepts rx_byte this cycle.
- rx_byte  out  BIT_WIDTH  received data, valid while valid=1.
- valid  out  1  holding register full.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: good byte arrived while holding register full; new byte dropped.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (rst=0, async): 2-flop sync chain = 1, state = IDLE, cnt = 0, bit index = 0, shift = 0, rx_byte = 0, valid = 0, frame_err = 0, overrun = 0, busy = 0.
- Synchroniser: rx_s is rx delayed by 2 clk edges. All decisions use rx_s only.
- cnt: width clog2(CLOCK_BAUD_RATIO). Increments each cycle in START/DATA/STOP. Cleared on every sample point and on entry to START.
- IDLE: rx_s=0 → START, cnt=0.
- START: at cnt==HALF-1, sample rx_s.
  - If 0 → DATA, cnt=0, idx=0.
  - If 1 → IDLE (glitch reject, no flag).
- DATA: at cnt==CLOCK_BAUD_RATIO-1, shift rx_s into the MSB of shift, right-shifting, so the first bit ends in bit 0. Set cnt=0, idx++. After idx reaches BIT_WIDTH-1's sample → STOP.
- STOP: at cnt==CLOCK_BAUD_RATIO-1, sample rx_s.
  - If 1 → deliver and go to IDLE.
  - If 0 → frame_err=1 for one cycle, byte discarded, go to BREAK.
- BREAK: stay until rx_s=1, then IDLE. A long low line produces exactly one frame_err.
- Deliver (same edge as the stop sample):
  - valid=0, or valid=1 with ready=1 in the same cycle → rx_byte=shift, valid=1, no overrun.
  - valid=1 and ready=0 → rx_byte unchanged, valid stays 1, overrun=1 for one cycle.
- Consume: valid=1 and ready=1 with no deliver → valid=0 next edge. rx_byte holds its value; it is don't-care when valid=0 but is not cleared.
- ready while valid=0 has no effect.
- Latency: rx falls between edges 0 and 1.
  - Stop sampled on edge 3+HALF+CLOCK_BAUD_RATIO×(BIT_WIDTH+1).
  - valid high after that edge.
  - Ratio 16, width 8 → edge 155.
- Back-to-back frames: a start bit detected in the cycle after STOP→IDLE is accepted. There is no dead time beyond the stop-sample point.
- Reset asserted mid-frame aborts immediately. After release the FSM waits in IDLE for a falling rx_s. A line still low at release is treated as a start bit.
- Outputs are registered. frame_err and overrun are never asserted in the same cycle.

Test Plan (CLOCK_BAUD_RATIO=16, BIT_WIDTH=8 unless stated):
- Single frame 0xA5, stop=1, ready=1 → valid high for exactly 1 cycle after edge 155, rx_byte=0xA5, no flags.
- Frames 0x3C then 0xFF back-to-back, ready held 0 → first: valid=1, rx_byte=0x3C. Second stop edge: overrun pulse, rx_byte stays 0x3C. Then ready=1 → valid=0.
- Second frame's deliver edge coincides with ready=1 on a pending 0x11 → rx_byte becomes the new byte, valid stays 1, overrun=0.
- rx low pulse of 5 cycles → START samples 1, returns to IDLE, valid=0, frame_err=0, busy drops.
- Frame 0x55 with stop=0, then line held low 100 cycles, then high → one frame_err pulse, valid=0. FSM in BREAK until rx_s=1, then IDLE. Next good frame 0x81 received correctly.
- rst asserted at edge 80 of a frame, released at 90, line back high → all outputs 0. The remainder of the aborted frame is ignored as data. The next clean frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Receive-side handshake bundle between the UART RX sequencer and its consumer.
// The slave modport belongs to the sequencer; the master modport belongs to the line driver and consumer.
interface uart_rx_ctrl_if #(
    parameter int unsigned BIT_WIDTH = 8
);
    logic                 rx;
    logic                 ready;
    logic [BIT_WIDTH-1:0] rx_byte;
    logic                 valid;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx,
        output ready,
        input  rx_byte,
        input  valid,
        input  frame_err,
        input  overrun,
        input  busy
    );

    modport slave (
        input  rx,
        input  ready,
        output rx_byte,
        output valid,
        output frame_err,
        output overrun,
        output busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises rx, times mid-bit sampling, and hands good frames
// to the consumer through a one-entry valid/ready holding register.
module uart_rx_ctrl #(
    parameter int unsigned CLOCK_BAUD_RATIO = 400,
    parameter int unsigned BIT_WIDTH        = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_ctrl_if.slave bus_io
);
    localparam int unsigned Half = CLOCK_BAUD_RATIO / 2;
    localparam int unsigned CntW = $clog2(CLOCK_BAUD_RATIO);
    localparam int unsigned IdxW = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [CntW-1:0] CntHalf = CntW'(Half - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLOCK_BAUD_RATIO - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(BIT_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e               state_q;
    logic [1:0]           sync_q;
    logic [CntW-1:0]      cnt_q;
    logic [IdxW-1:0]      idx_q;
    logic [BIT_WIDTH-1:0] shift_q;
    logic [BIT_WIDTH-1:0] rx_byte_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    logic                 rx_s;
    logic [CntW-1:0]      cnt_inc;
    logic [BIT_WIDTH-1:0] shift_d;

    assign rx_s    = sync_q[1];
    assign cnt_inc = cnt_q + CntW'(1);

    // Right shift with the new bit entering at the MSB, so the first bit lands in bit 0.
    always_comb begin
        shift_d              = shift_q >> 1;
        shift_d[BIT_WIDTH-1] = rx_s;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], bus_io.rx};
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (valid_q && bus_io.ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                    end
                end
                StStart: begin
                    if (cnt_q == CntHalf) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rx_s ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StData: begin
                    if (cnt_q == CntLast) begin
                        cnt_q   <= '0;
                        shift_q <= shift_d;
                        idx_q   <= idx_q + IdxW'(1);
                        if (idx_q == IdxLast) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StStop: begin
                    if (cnt_q == CntLast) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= StIdle;
                            // Delivery overrides the consume above when both happen on this edge.
                            if (!valid_q || bus_io.ready) begin
                                rx_byte_q <= shift_q;
                                valid_q   <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StBreak;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StBreak: begin
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.rx_byte   = rx_byte_q;
    assign bus_io.valid     = valid_q;
    assign bus_io.frame_err = frame_err_q;
    assign bus_io.overrun   = overrun_q;
    assign bus_io.busy      = (state_q != StIdle);
endmodule
